// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Control unit for the 32-bit multicycle datapath. It runs one instruction
//   at a time through IF / DEC / execute / memory / write-back. It also drives
//   every mux select and load enable of the PC, IR, register file, ALU,
//   immediate extender and data memory.
//
// Parameters
//   MEM_WAIT       extra wait cycles per data-memory access (0..15)
//
// Ports
//   Clk            in   rising-edge clock
//   Reset_n        in   asynchronous active-low reset
//   Instr[31:0]    in   IR contents (opcode = Instr[31:26], func = Instr[5:0])
//   ALU_zero       in   ALU zero flag, looked at only in the BR state
//   PC_LdEn        out  PC load enable
//   PC_sel         out  0: PC+4, 1: PC+4+branch offset
//   IR_LdEn        out  latch instruction memory output into IR
//   RF_WrEn        out  register-file write enable
//   RF_WrData_sel  out  0: ALU result, 1: memory data
//   RF_B_sel       out  0: Instr[15:11], 1: Instr[20:16]
//   ALU_Bin_sel    out  0: RF B, 1: extended immediate
//   ImmExt[1:0]    out  00 sign-ext, 01 zero-fill, 10 Imm<<16, 11 sign-ext<<2
//   ALU_func[3:0]  out  ALU operation
//   MEM_WrEn       out  data-memory write enable
//   ByteOp         out  1 for lb/sb
//   Halt           out  illegal-instruction trap indicator
//
// Build option
//   ILLEGAL_TRAP_EN  defined: an illegal instruction parks the FSM in HALT
//                    with Halt=1 until reset. Undefined: an illegal
//                    instruction runs as a 4-cycle NOP (no RF write, PC+4),
//                    and Halt is tied 0.
//
// Outputs are registered and decoded from the next state, so they are valid
// during the whole cycle in which a state is entered. PC_sel is the one
// exception. The branch decision needs ALU_zero from the BR cycle itself,
// so PC_sel is formed combinationally in BR.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [1:0]  ImmExt,
    output logic [3:0]  ALU_func,
    output logic        MEM_WrEn,
    output logic        ByteOp,
    output logic        Halt
);

    typedef enum logic [3:0] {
        S_IF, S_DEC, S_EX_R, S_EX_I, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB, S_BR
`ifdef ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_B     = 6'b111111;

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic       pc_ld_en_q, pc_ld_en_d;
    logic       ir_ld_en_q, ir_ld_en_d;
    logic       rf_wr_en_q, rf_wr_en_d;
    logic       rf_wr_data_sel_q, rf_wr_data_sel_d;
    logic       rf_b_sel_q, rf_b_sel_d;
    logic       alu_bin_sel_q, alu_bin_sel_d;
    logic [1:0] imm_ext_q, imm_ext_d;
    logic [3:0] alu_func_q, alu_func_d;
    logic       mem_wr_en_q, mem_wr_en_d;
    logic       byte_op_q, byte_op_d;

    // Instruction decode (meaningful from DEC onward, once IR holds the instruction)
    logic [5:0] opcode, func;
    logic       r_ok, is_ialu, is_load, is_store, is_beq, is_bne, is_b, is_branch, illegal;
    logic       unused_instr_bits;

    assign opcode    = Instr[31:26];
    assign func      = Instr[5:0];
    assign r_ok      = (opcode == OP_RTYPE) && (func[5:4] == 2'b11);
    assign is_ialu   = (opcode == OP_LI) || (opcode == OP_LUI) || (opcode == OP_ADDI) ||
                       (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_load   = (opcode == OP_LB) || (opcode == OP_LW);
    assign is_store  = (opcode == OP_SB) || (opcode == OP_SW);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_b      = (opcode == OP_B);
    assign is_branch = is_beq || is_bne || is_b;
    assign illegal   = !(r_ok || is_ialu || is_load || is_store || is_branch);
    // Register-number fields feed the datapath directly, not the controller
    assign unused_instr_bits = ^Instr[25:6];

    // Operand profile: the selects an instruction holds in every state after DEC
    logic       prof_b_sel, prof_bin_sel, prof_byte;
    logic [1:0] prof_imm;
    logic [3:0] prof_func;

    always_comb begin
        prof_b_sel   = 1'b0;
        prof_bin_sel = 1'b0;
        prof_byte    = 1'b0;
        prof_imm     = 2'b00;
        prof_func    = 4'b0000;
        if (r_ok) begin
            prof_func = func[3:0];
        end else if (is_ialu) begin
            prof_b_sel   = 1'b1;
            prof_bin_sel = 1'b1;
            case (opcode)
                OP_LUI:  prof_imm = 2'b10;
                OP_ANDI: begin prof_imm = 2'b01; prof_func = 4'b0010; end
                OP_ORI:  begin prof_imm = 2'b01; prof_func = 4'b0011; end
                default: ;
            endcase
        end else if (is_load || is_store) begin
            prof_b_sel   = 1'b1;
            prof_bin_sel = 1'b1;
            prof_byte    = (opcode == OP_LB) || (opcode == OP_SB);
        end else if (is_branch) begin
            prof_b_sel = 1'b1;
            prof_imm   = 2'b11;
            prof_func  = 4'b0001;
        end
    end

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            // IF entered through reset has IR_LdEn low, so IF is entered once more
            // to load IR before decoding.
            S_IF:     state_d = ir_ld_en_q ? S_DEC : S_IF;
            S_DEC: begin
                if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_EX_R;
`endif
                end else if (r_ok)                  state_d = S_EX_R;
                else if (is_ialu)                   state_d = S_EX_I;
                else if (is_load || is_store)       state_d = S_ADDR;
                else                                state_d = S_BR;
            end
            S_EX_R, S_EX_I: state_d = S_WB;
            S_ADDR:   state_d = is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = (cnt_q == MEM_WAIT_C) ? S_WB : S_MEM_RD;
            S_MEM_WR: state_d = (cnt_q == MEM_WAIT_C) ? S_IF : S_MEM_WR;
            S_WB, S_BR: state_d = S_IF;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_IF;
        endcase

        cnt_d = 4'd0;
        if ((state_d == state_q) && ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)))
            cnt_d = (cnt_q == MEM_WAIT_C) ? cnt_q : cnt_q + 4'd1;
    end

    // Registered outputs decoded from the state being entered
`ifdef ILLEGAL_TRAP_EN
    logic halt_q, halt_d;
`endif

    always_comb begin
        pc_ld_en_d       = 1'b0;
        ir_ld_en_d       = 1'b0;
        rf_wr_en_d       = 1'b0;
        rf_wr_data_sel_d = 1'b0;
        rf_b_sel_d       = 1'b0;
        alu_bin_sel_d    = 1'b0;
        imm_ext_d        = 2'b00;
        alu_func_d       = 4'b0000;
        mem_wr_en_d      = 1'b0;
        byte_op_d        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        halt_d           = 1'b0;
`endif
        case (state_d)
            S_IF:  ir_ld_en_d = 1'b1;
            S_DEC: ;
`ifdef ILLEGAL_TRAP_EN
            S_HALT: halt_d = 1'b1;
`endif
            default: begin
                rf_b_sel_d    = prof_b_sel;
                alu_bin_sel_d = prof_bin_sel;
                imm_ext_d     = prof_imm;
                alu_func_d    = prof_func;
                byte_op_d     = prof_byte;
                case (state_d)
                    S_WB: begin
                        // Illegal instructions reach WB only as a NOP
                        rf_wr_en_d       = !illegal;
                        rf_wr_data_sel_d = (state_q == S_MEM_RD);
                        pc_ld_en_d       = 1'b1;
                    end
                    S_MEM_WR: begin
                        mem_wr_en_d = 1'b1;
                        pc_ld_en_d  = (cnt_d == MEM_WAIT_C);
                    end
                    S_BR:    pc_ld_en_d = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q          <= S_IF;
            cnt_q            <= 4'd0;
            pc_ld_en_q       <= 1'b0;
            ir_ld_en_q       <= 1'b0;
            rf_wr_en_q       <= 1'b0;
            rf_wr_data_sel_q <= 1'b0;
            rf_b_sel_q       <= 1'b0;
            alu_bin_sel_q    <= 1'b0;
            imm_ext_q        <= 2'b00;
            alu_func_q       <= 4'b0000;
            mem_wr_en_q      <= 1'b0;
            byte_op_q        <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            halt_q           <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pc_ld_en_q       <= pc_ld_en_d;
            ir_ld_en_q       <= ir_ld_en_d;
            rf_wr_en_q       <= rf_wr_en_d;
            rf_wr_data_sel_q <= rf_wr_data_sel_d;
            rf_b_sel_q       <= rf_b_sel_d;
            alu_bin_sel_q    <= alu_bin_sel_d;
            imm_ext_q        <= imm_ext_d;
            alu_func_q       <= alu_func_d;
            mem_wr_en_q      <= mem_wr_en_d;
            byte_op_q        <= byte_op_d;
`ifdef ILLEGAL_TRAP_EN
            halt_q           <= halt_d;
`endif
        end
    end

    assign PC_LdEn       = pc_ld_en_q;
    assign PC_sel        = (state_q == S_BR) &&
                           (is_b || (is_beq && ALU_zero) || (is_bne && !ALU_zero));
    assign IR_LdEn       = ir_ld_en_q;
    assign RF_WrEn       = rf_wr_en_q;
    assign RF_WrData_sel = rf_wr_data_sel_q;
    assign RF_B_sel      = rf_b_sel_q;
    assign ALU_Bin_sel   = alu_bin_sel_q;
    assign ImmExt        = imm_ext_q;
    assign ALU_func      = alu_func_q;
    assign MEM_WrEn      = mem_wr_en_q;
    assign ByteOp        = byte_op_q;
`ifdef ILLEGAL_TRAP_EN
    assign Halt          = halt_q;
`else
    assign Halt          = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm. Two instances (MEM_WAIT=0 and 2) share
// clock and reset; each has its own IR contents. Expected per-cycle output
// vectors are built per instruction from the instruction-level timing rules.
module tb_multicycle_ctrl_fsm;

    // Output vector bit positions
    localparam logic [15:0] PCLD   = 16'h0001;
    localparam logic [15:0] PCSEL  = 16'h0002;
    localparam logic [15:0] IRLD   = 16'h0004;
    localparam logic [15:0] RFWR   = 16'h0008;
    localparam logic [15:0] WDSEL  = 16'h0010;
    localparam logic [15:0] BSEL   = 16'h0020;
    localparam logic [15:0] BINSEL = 16'h0040;
    localparam logic [15:0] MEMWR  = 16'h2000;
    localparam logic [15:0] BYTEOP = 16'h4000;
    localparam logic [15:0] HALT   = 16'h8000;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        ALU_zero = 1'b0;
    logic [31:0] instr_v [2];
    logic [15:0] obs [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];
    int br_idx;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pc_ld_en, pc_sel, ir_ld_en, rf_wr_en, rf_wd_sel, rf_b_sel;
        logic       alu_bin_sel, mem_wr_en, byte_op, halt;
        logic [1:0] imm_ext;
        logic [3:0] alu_func;
        multicycle_ctrl_fsm #(.MEM_WAIT((g == 0) ? 0 : 2)) u_dut (
            .Clk(Clk), .Reset_n(Reset_n), .Instr(instr_v[g]), .ALU_zero(ALU_zero),
            .PC_LdEn(pc_ld_en), .PC_sel(pc_sel), .IR_LdEn(ir_ld_en), .RF_WrEn(rf_wr_en),
            .RF_WrData_sel(rf_wd_sel), .RF_B_sel(rf_b_sel), .ALU_Bin_sel(alu_bin_sel),
            .ImmExt(imm_ext), .ALU_func(alu_func), .MEM_WrEn(mem_wr_en),
            .ByteOp(byte_op), .Halt(halt)
        );
        assign obs[g] = {halt, byte_op, mem_wr_en, alu_func, imm_ext, alu_bin_sel,
                         rf_b_sel, rf_wd_sel, rf_wr_en, ir_ld_en, pc_sel, pc_ld_en};
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected cycle-by-cycle outputs of one instruction, starting with its IF cycle
    task automatic build_exp(input logic [31:0] ins, input bit z, input int mw, input int halt_len);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] prof;
        int          cls;   // 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 illegal
        bit          taken;
        op = ins[31:26];
        fn = ins[5:0];
        prof = 16'h0;
        taken = 1'b0;
        cls = 5;
        case (op)
            6'b100000: if (fn[5:4] == 2'b11) begin cls = 0; prof = 16'(fn[3:0]) << 9; end
            6'b111000, 6'b110000: begin cls = 1; prof = BSEL | BINSEL; end
            6'b111001: begin cls = 1; prof = BSEL | BINSEL | (16'h2 << 7); end
            6'b110010: begin cls = 1; prof = BSEL | BINSEL | (16'h1 << 7) | (16'h2 << 9); end
            6'b110011: begin cls = 1; prof = BSEL | BINSEL | (16'h1 << 7) | (16'h3 << 9); end
            6'b000011: begin cls = 2; prof = BSEL | BINSEL | BYTEOP; end
            6'b001111: begin cls = 2; prof = BSEL | BINSEL; end
            6'b000111: begin cls = 3; prof = BSEL | BINSEL | BYTEOP; end
            6'b011111: begin cls = 3; prof = BSEL | BINSEL; end
            6'b000000: begin cls = 4; taken = z; end
            6'b000001: begin cls = 4; taken = !z; end
            6'b111111: begin cls = 4; taken = 1'b1; end
            default: cls = 5;
        endcase
        if (cls == 4) prof = BSEL | (16'h3 << 7) | (16'h1 << 9);
        exp_q.delete();
        br_idx = -1;
        exp_q.push_back(IRLD);
        exp_q.push_back(16'h0);
        case (cls)
            0, 1: begin
                exp_q.push_back(prof);
                exp_q.push_back(prof | RFWR | PCLD);
            end
            2: begin
                exp_q.push_back(prof);
                for (int k = 0; k <= mw; k++) exp_q.push_back(prof);
                exp_q.push_back(prof | RFWR | WDSEL | PCLD);
            end
            3: begin
                exp_q.push_back(prof);
                for (int k = 0; k <= mw; k++) exp_q.push_back(prof | MEMWR | ((k == mw) ? PCLD : 16'h0));
            end
            4: begin
                br_idx = 2;
                exp_q.push_back(prof | PCLD | (taken ? PCSEL : 16'h0));
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int k = 0; k < halt_len; k++) exp_q.push_back(HALT);
`else
                exp_q.push_back(16'h0);
                exp_q.push_back(PCLD);
`endif
            end
        endcase
    endtask

    // Runs one instruction on DUT d; stop_at >= 0 ends the run after that cycle
    task automatic run_instr(input int d, input logic [31:0] ins, input bit z,
                             input string name, input int stop_at);
        build_exp(ins, z, (d == 0) ? 0 : 2, 20);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (stop_at >= 0 && i > stop_at) break;
            @(posedge Clk);
            ALU_zero = (i == br_idx) ? z : 1'($urandom_range(0, 1));
            #1;
            check($sformatf("d%0d %s cyc%0d", d, name, i), obs[d], exp_q[i]);
            if (i == 0) instr_v[d] = ins;
        end
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("reset_d0", obs[0], 16'h0);
        check("reset_d1", obs[1], 16'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr(input bit allow_ill);
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        int          k;
        r = $urandom;
        k = $urandom_range(0, allow_ill ? 14 : 12);
        case (k)
            0:  op = 6'b100000;  1: op = 6'b111000;  2: op = 6'b111001;
            3:  op = 6'b110000;  4: op = 6'b110010;  5: op = 6'b110011;
            6:  op = 6'b000011;  7: op = 6'b001111;  8: op = 6'b000111;
            9:  op = 6'b011111; 10: op = 6'b000000; 11: op = 6'b000001;
            12: op = 6'b111111; 13: op = 6'b101010;
            default: op = 6'b010101;
        endcase
        fn = r[5:0];
        if (op == 6'b100000 && (!allow_ill || r[31])) fn[5:4] = 2'b11;
        return {op, r[25:6], fn};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit ill_ok;
`ifdef ILLEGAL_TRAP_EN
        ill_ok = 1'b0;
`else
        ill_ok = 1'b1;
`endif
        instr_v[0] = 32'h0;
        instr_v[1] = 32'h0;

        // MEM_WAIT = 0 instance
        apply_reset();
        run_instr(0, {6'b110011, 5'd2, 5'd3, 16'h8001}, 1'b0, "ori", -1);
        run_instr(0, {6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b110000}, 1'b0, "add", -1);
        run_instr(0, {6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b110001}, 1'b0, "sub", -1);
        run_instr(0, {6'b011111, 5'd1, 5'd2, 16'h0010}, 1'b0, "sw", -1);
        run_instr(0, {6'b000111, 5'd1, 5'd2, 16'hfff0}, 1'b0, "sb", -1);
        run_instr(0, {6'b000000, 5'd1, 5'd2, 16'h0004}, 1'b1, "beq_z1", -1);
        run_instr(0, {6'b000000, 5'd1, 5'd2, 16'h0004}, 1'b0, "beq_z0", -1);
        run_instr(0, {6'b000001, 5'd1, 5'd2, 16'h0004}, 1'b1, "bne_z1", -1);
        run_instr(0, {6'b000001, 5'd1, 5'd2, 16'h0004}, 1'b0, "bne_z0", -1);
        run_instr(0, {6'b111111, 5'd0, 5'd0, 16'hfffc}, 1'b0, "b_z0", -1);
        run_instr(0, {6'b111111, 5'd0, 5'd0, 16'hfffc}, 1'b1, "b_z1", -1);
        run_instr(0, {6'b001111, 5'd1, 5'd2, 16'h0008}, 1'b0, "lw", -1);
        run_instr(0, {6'b000011, 5'd1, 5'd2, 16'h0001}, 1'b0, "lb", -1);
        run_instr(0, {6'b110010, 5'd1, 5'd2, 16'h00ff}, 1'b0, "andi", -1);
        run_instr(0, {6'b111001, 5'd0, 5'd2, 16'h1234}, 1'b0, "lui", -1);
        run_instr(0, {6'b111000, 5'd0, 5'd2, 16'h8000}, 1'b0, "li", -1);
        run_instr(0, {6'b110000, 5'd1, 5'd2, 16'h7fff}, 1'b0, "addi", -1);
        run_instr(0, {6'b101010, 26'h0}, 1'b0, "illegal_op", -1);
`ifdef ILLEGAL_TRAP_EN
        apply_reset();
`endif
        run_instr(0, {6'b100000, 20'h0, 6'b000010}, 1'b0, "illegal_func", -1);
`ifdef ILLEGAL_TRAP_EN
        apply_reset();
`endif

        // Reset while in EX_R: outputs clear at once, next cycle re-fetches
        run_instr(0, {6'b100000, 5'd4, 5'd5, 5'd6, 5'd0, 6'b110010}, 1'b0, "rst_mid", 2);
        Reset_n = 1'b0;
        #1;
        check("mid_reset_zero", obs[0], 16'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_instr(0, {6'b100000, 5'd4, 5'd5, 5'd6, 5'd0, 6'b110011}, 1'b0, "after_rst", -1);

        for (int n = 0; n < 60; n++)
            run_instr(0, rand_instr(ill_ok), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), -1);

        // MEM_WAIT = 2 instance
        apply_reset();
        run_instr(1, {6'b001111, 5'd1, 5'd2, 16'h0008}, 1'b0, "lw_w2", -1);
        run_instr(1, {6'b000011, 5'd1, 5'd2, 16'h0003}, 1'b0, "lb_w2", -1);
        run_instr(1, {6'b011111, 5'd1, 5'd2, 16'h000c}, 1'b0, "sw_w2", -1);
        run_instr(1, {6'b000111, 5'd1, 5'd2, 16'h000d}, 1'b0, "sb_w2", -1);
        run_instr(1, {6'b110011, 5'd2, 5'd3, 16'h8001}, 1'b0, "ori_w2", -1);
        run_instr(1, {6'b000000, 5'd1, 5'd2, 16'h0004}, 1'b1, "beq_w2", -1);
        for (int n = 0; n < 40; n++)
            run_instr(1, rand_instr(ill_ok), 1'($urandom_range(0, 1)), $sformatf("rndw%0d", n), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
